// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the IF and MEM ports.
// MEM has priority. Each returned word is held until its pipeline stage advances.
// A flush lets the outstanding bus cycle complete, then discards its result.
// Optional feature macro: BUS_TIMEOUT_EN aborts a cycle after TIMEOUT_CYCLES
// cycles without an ack and raises bus_err_if / bus_err_mem.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic        if_ce,
   input  logic [31:0] if_addr,
   output logic [31:0] if_inst,
   output logic        stallreq_if,
   input  logic        mem_ce,
   input  logic        mem_we,
   input  logic [3:0]  mem_sel,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        stallreq_mem,
   output logic        bus_cyc_o,
   output logic        bus_stb_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_data_o,
   input  logic [31:0] bus_data_i,
   input  logic        bus_ack_i,
   output logic        bus_err_if,
   output logic        bus_err_mem
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      BUSY_MEM   = 2'd1,
      BUSY_IF    = 2'd2,
      WAIT_FLUSH = 2'd3
   } state_t;

   state_t      state_r, state_s;
   logic        if_done_r, if_done_s;
   logic        mem_done_r, mem_done_s;
   logic [31:0] if_inst_r, if_inst_s;
   logic [31:0] mem_rdata_r, mem_rdata_s;
   logic        cyc_r, cyc_s;
   logic        we_r, we_s;
   logic [3:0]  sel_r, sel_s;
   logic [31:0] addr_r, addr_s;
   logic [31:0] wdata_r, wdata_s;
   logic        timeout_s;
   logic        unused_stall_s;

   // Only the IF and MEM stall bits matter to this block.
   assign unused_stall_s = ^{stall[5], stall[3:2], stall[0]};

   // The timeout count is an 8-bit quantity; reject settings it cannot reach.
   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("mem_bus_arbiter: TIMEOUT_CYCLES must be within 1..255");
   end

`ifdef BUS_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   logic [7:0] cnt_r;
   logic       err_if_r;
   logic       err_mem_r;

   // Wait counter: zero while idle (so it restarts with every transaction), counts ack-less busy cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_r <= 8'd0;
      end else if (state_r == IDLE) begin
         cnt_r <= 8'd0;
      end else if (!bus_ack_i) begin
         cnt_r <= cnt_r + 8'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign timeout_s = (state_r != IDLE) && !bus_ack_i && ((cnt_r + 8'd1) == TIMEOUT_LIMIT);

   // Error flags ride along with their done flag; set only when the done flag came from a timeout.
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_if_r  <= 1'b0;
         err_mem_r <= 1'b0;
      end else begin
         err_if_r  <= if_done_s  & (err_if_r  | (timeout_s && state_r == BUSY_IF  && !flush));
         err_mem_r <= mem_done_s & (err_mem_r | (timeout_s && state_r == BUSY_MEM && !flush));
      end
   end

   assign bus_err_if  = err_if_r;
   assign bus_err_mem = err_mem_r;
`else
   assign timeout_s   = 1'b0;
   assign bus_err_if  = 1'b0;
   assign bus_err_mem = 1'b0;
`endif

   // Next-state, bus-output and result-buffer logic.
   always_comb begin
      state_s     = state_r;
      cyc_s       = cyc_r;
      we_s        = we_r;
      sel_s       = sel_r;
      addr_s      = addr_r;
      wdata_s     = wdata_r;
      if_inst_s   = if_inst_r;
      mem_rdata_s = mem_rdata_r;

      // Buffered results are released when the stage advances or the pipe flushes.
      if (flush || !stall[1]) begin
         if_done_s = 1'b0;
      end else begin
         if_done_s = if_done_r;
      end
      if (flush || !stall[4]) begin
         mem_done_s = 1'b0;
      end else begin
         mem_done_s = mem_done_r;
      end

      case (state_r)
         IDLE: begin
            if (flush) begin
               state_s = IDLE;
            end else if (mem_ce && !mem_done_r) begin
               state_s = BUSY_MEM;
               cyc_s   = 1'b1;
               we_s    = mem_we;
               sel_s   = mem_sel;
               addr_s  = mem_addr;
               wdata_s = mem_wdata;
            end else if (if_ce && !if_done_r) begin
               state_s = BUSY_IF;
               cyc_s   = 1'b1;
               we_s    = 1'b0;
               sel_s   = 4'b1111;
               addr_s  = if_addr;
               wdata_s = 32'h0000_0000;
            end else begin
               state_s = IDLE;
            end
         end
         BUSY_MEM, BUSY_IF: begin
            if (bus_ack_i || timeout_s) begin
               state_s = IDLE;
               cyc_s   = 1'b0;
               we_s    = 1'b0;
               if (flush) begin
                  state_s = IDLE;
               end else if (state_r == BUSY_MEM) begin
                  mem_done_s = 1'b1;
                  if (timeout_s) begin
                     mem_rdata_s = 32'h0000_0000;
                  end else if (!we_r) begin
                     mem_rdata_s = bus_data_i;
                  end else begin
                     mem_rdata_s = mem_rdata_r;
                  end
               end else begin
                  if_done_s = 1'b1;
                  if (timeout_s) begin
                     if_inst_s = 32'h0000_0000;
                  end else begin
                     if_inst_s = bus_data_i;
                  end
               end
            end else if (flush) begin
               state_s = WAIT_FLUSH;
            end else begin
               state_s = state_r;
            end
         end
         WAIT_FLUSH: begin
            if (bus_ack_i || timeout_s) begin
               state_s = IDLE;
               cyc_s   = 1'b0;
               we_s    = 1'b0;
            end else begin
               state_s = WAIT_FLUSH;
            end
         end
         default: begin
            state_s = IDLE;
            cyc_s   = 1'b0;
            we_s    = 1'b0;
         end
      endcase
   end

   // State and output registers; reset also abandons any bus cycle in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= IDLE;
         if_done_r   <= 1'b0;
         mem_done_r  <= 1'b0;
         if_inst_r   <= 32'h0000_0000;
         mem_rdata_r <= 32'h0000_0000;
         cyc_r       <= 1'b0;
         we_r        <= 1'b0;
         sel_r       <= 4'b0000;
         addr_r      <= 32'h0000_0000;
         wdata_r     <= 32'h0000_0000;
      end else begin
         state_r     <= state_s;
         if_done_r   <= if_done_s;
         mem_done_r  <= mem_done_s;
         if_inst_r   <= if_inst_s;
         mem_rdata_r <= mem_rdata_s;
         cyc_r       <= cyc_s;
         we_r        <= we_s;
         sel_r       <= sel_s;
         addr_r      <= addr_s;
         wdata_r     <= wdata_s;
      end
   end

   assign stallreq_if  = if_ce  & ~if_done_r;
   assign stallreq_mem = mem_ce & ~mem_done_r;
   assign if_inst      = if_inst_r;
   assign mem_rdata    = mem_rdata_r;
   assign bus_cyc_o    = cyc_r;
   assign bus_stb_o    = cyc_r;
   assign bus_we_o     = we_r;
   assign bus_sel_o    = sel_r;
   assign bus_addr_o   = addr_r;
   assign bus_data_o   = wdata_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, IF fetch, MEM priority, store with
// held stall, flush handling, mid-transaction reset and (with BUS_TIMEOUT_EN) timeout.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic        if_ce;
   logic [31:0] if_addr;
   logic [31:0] if_inst;
   logic        stallreq_if;
   logic        mem_ce;
   logic        mem_we;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stallreq_mem;
   logic        bus_cyc_o;
   logic        bus_stb_o;
   logic        bus_we_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_data_o;
   logic [31:0] bus_data_i;
   logic        bus_ack_i;
   logic        bus_err_if;
   logic        bus_err_mem;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .if_ce(if_ce), .if_addr(if_addr), .if_inst(if_inst), .stallreq_if(stallreq_if),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stallreq_mem(stallreq_mem),
      .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
      .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
      .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i),
      .bus_err_if(bus_err_if), .bus_err_mem(bus_err_mem)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; stall = 6'b000000; flush = 1'b0;
      if_ce = 1'b0; if_addr = 32'h0;
      mem_ce = 1'b0; mem_we = 1'b0; mem_sel = 4'b0000; mem_addr = 32'h0; mem_wdata = 32'h0;
      bus_data_i = 32'h0; bus_ack_i = 1'b0;

      // Reset held for three cycles
      step(); step(); step();
      check("rst_cyc",      {31'd0, bus_cyc_o},   32'd0);
      check("rst_stb",      {31'd0, bus_stb_o},   32'd0);
      check("rst_we",       {31'd0, bus_we_o},    32'd0);
      check("rst_sel",      {28'd0, bus_sel_o},   32'd0);
      check("rst_addr",     bus_addr_o,           32'h0);
      check("rst_wdata",    bus_data_o,           32'h0);
      check("rst_if_inst",  if_inst,              32'h0);
      check("rst_rdata",    mem_rdata,            32'h0);
      check("rst_errs",     {30'd0, bus_err_if, bus_err_mem}, 32'd0);

      // IF fetch, zero-wait slave
      rst = 1'b1; if_ce = 1'b1; if_addr = 32'h0000_0100; stall = 6'b000010;
      #1;
      check("t1_stallreq_c1", {31'd0, stallreq_if}, 32'd1);
      step();
      check("t1_cyc",  {31'd0, bus_cyc_o},  32'd1);
      check("t1_stb",  {31'd0, bus_stb_o},  32'd1);
      check("t1_addr", bus_addr_o,          32'h0000_0100);
      check("t1_sel",  {28'd0, bus_sel_o},  32'h0000_000F);
      check("t1_we",   {31'd0, bus_we_o},   32'd0);
      check("t1_stallreq_c2", {31'd0, stallreq_if}, 32'd1);
      bus_ack_i = 1'b1; bus_data_i = 32'h3C01_0001;
      step();
      bus_ack_i = 1'b0;
      check("t1_cyc_drop",   {31'd0, bus_cyc_o},   32'd0);
      check("t1_if_inst",    if_inst,              32'h3C01_0001);
      check("t1_stallreq_c3", {31'd0, stallreq_if}, 32'd0);
      if_ce = 1'b0; stall = 6'b000000;
      step();

      // IF and MEM together: MEM load first, two wait cycles
      if_ce = 1'b1; if_addr = 32'h0000_0104;
      mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'b1111; mem_addr = 32'h0000_1000;
      stall = 6'b010010;
      step();
      check("t2_cyc",      {31'd0, bus_cyc_o}, 32'd1);
      check("t2_mem_addr", bus_addr_o,         32'h0000_1000);
      check("t2_mem_we",   {31'd0, bus_we_o},  32'd0);
      step();
      check("t2_addr_held", bus_addr_o,          32'h0000_1000);
      check("t2_if_wait",   {31'd0, stallreq_if}, 32'd1);
      step();
      bus_ack_i = 1'b1; bus_data_i = 32'hCAFE_F00D;
      step();
      bus_ack_i = 1'b0;
      check("t2_gap_cyc",    {31'd0, bus_cyc_o},    32'd0);
      check("t2_rdata",      mem_rdata,             32'hCAFE_F00D);
      check("t2_sreq_mem",   {31'd0, stallreq_mem}, 32'd0);
      check("t2_sreq_if",    {31'd0, stallreq_if},  32'd1);
      check("t2_err_mem",    {31'd0, bus_err_mem},  32'd0);
      step();
      check("t2_if_cyc",  {31'd0, bus_cyc_o}, 32'd1);
      check("t2_if_addr", bus_addr_o,         32'h0000_0104);
      bus_ack_i = 1'b1; bus_data_i = 32'h2402_0005;
      step();
      bus_ack_i = 1'b0;
      check("t2_if_inst",  if_inst,              32'h2402_0005);
      check("t2_if_sreq",  {31'd0, stallreq_if}, 32'd0);
      if_ce = 1'b0; mem_ce = 1'b0; stall = 6'b000000;
      step();

      // MEM store, stall[4] held four cycles after ack
      mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011;
      mem_addr = 32'h0000_2000; mem_wdata = 32'hDEAD_BEEF; stall = 6'b010000;
      step();
      check("t3_we",    {31'd0, bus_we_o},  32'd1);
      check("t3_sel",   {28'd0, bus_sel_o}, 32'h0000_0003);
      check("t3_wdata", bus_data_o,         32'hDEAD_BEEF);
      bus_ack_i = 1'b1; bus_data_i = 32'h1111_1111;
      step();
      bus_ack_i = 1'b0;
      check("t3_we_drop", {31'd0, bus_we_o},     32'd0);
      check("t3_sreq",    {31'd0, stallreq_mem}, 32'd0);
      check("t3_rdata",   mem_rdata,             32'hCAFE_F00D);
      for (int i = 0; i < 4; i++) begin
         step();
         check("t3_no_reissue", {31'd0, bus_cyc_o},    32'd0);
         check("t3_sreq_held",  {31'd0, stallreq_mem}, 32'd0);
      end
      mem_ce = 1'b0; mem_we = 1'b0; stall = 6'b000000;
      step();

      // Flush during the second wait cycle of an IF read
      if_ce = 1'b1; if_addr = 32'h0000_0108; stall = 6'b000010;
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("t4_cyc_held",  {31'd0, bus_cyc_o}, 32'd1);
      check("t4_addr_held", bus_addr_o,         32'h0000_0108);
      step();
      check("t4_cyc_held2", {31'd0, bus_cyc_o}, 32'd1);
      bus_ack_i = 1'b1; bus_data_i = 32'h9999_9999;
      step();
      bus_ack_i = 1'b0;
      check("t4_cyc_drop", {31'd0, bus_cyc_o},   32'd0);
      check("t4_if_inst",  if_inst,              32'h2402_0005);
      check("t4_not_done", {31'd0, stallreq_if}, 32'd1);
      step();
      check("t4_refetch_cyc",  {31'd0, bus_cyc_o}, 32'd1);
      check("t4_refetch_addr", bus_addr_o,         32'h0000_0108);
      bus_ack_i = 1'b1; bus_data_i = 32'h8C43_0000;
      step();
      bus_ack_i = 1'b0;
      check("t4_refetch_inst", if_inst,              32'h8C43_0000);
      check("t4_refetch_sreq", {31'd0, stallreq_if}, 32'd0);
      if_ce = 1'b0; stall = 6'b000000;
      step();

      // Reset in the middle of a BUSY_MEM wait
      mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'b1111; mem_addr = 32'h0000_3000; stall = 6'b010000;
      step();
      check("t5_cyc", {31'd0, bus_cyc_o}, 32'd1);
      step();
      rst = 1'b0;
      step();
      check("t5_cyc",   {31'd0, bus_cyc_o}, 32'd0);
      check("t5_stb",   {31'd0, bus_stb_o}, 32'd0);
      check("t5_addr",  bus_addr_o,         32'h0);
      check("t5_rdata", mem_rdata,          32'h0);
      check("t5_inst",  if_inst,            32'h0);
      rst = 1'b1; mem_ce = 1'b0;
      step();
      check("t5_idle", {31'd0, bus_cyc_o}, 32'd0);

      // Flush arriving together with the ack discards the load
      mem_ce = 1'b1; mem_addr = 32'h0000_3004; stall = 6'b010000;
      step();
      check("t6_cyc", {31'd0, bus_cyc_o}, 32'd1);
      bus_ack_i = 1'b1; bus_data_i = 32'h55AA_55AA; flush = 1'b1;
      step();
      bus_ack_i = 1'b0; flush = 1'b0;
      check("t6_cyc_drop", {31'd0, bus_cyc_o},    32'd0);
      check("t6_rdata",    mem_rdata,             32'h0);
      check("t6_sreq",     {31'd0, stallreq_mem}, 32'd1);
      step();
      check("t6_reissue", {31'd0, bus_cyc_o}, 32'd1);
      bus_ack_i = 1'b1; bus_data_i = 32'h1234_5678;
      step();
      bus_ack_i = 1'b0;
      check("t6_rdata2", mem_rdata,             32'h1234_5678);
      check("t6_sreq2",  {31'd0, stallreq_mem}, 32'd0);
      mem_ce = 1'b0; stall = 6'b000000;
      step();

`ifdef BUS_TIMEOUT_EN
      // Slave never acks: abort after four busy cycles
      mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_4000; stall = 6'b010000;
      step();
      step();
      step();
      step();
      check("t7_cyc_busy4", {31'd0, bus_cyc_o}, 32'd1);
      step();
      check("t7_cyc_drop", {31'd0, bus_cyc_o},    32'd0);
      check("t7_err_mem",  {31'd0, bus_err_mem},  32'd1);
      check("t7_rdata",    mem_rdata,             32'h0);
      check("t7_sreq",     {31'd0, stallreq_mem}, 32'd0);
      mem_ce = 1'b0; stall = 6'b000000;
      step();
      check("t7_err_clr", {31'd0, bus_err_mem}, 32'd0);
`else
      check("t7_err_tied", {30'd0, bus_err_if, bus_err_mem}, 32'd0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external memory bus between the instruction-fetch port (IF) and the data-access port (MEM) of the five-stage pipeline. It issues one bus transaction at a time, with MEM having priority over IF. It raises per-port stall requests to the pipeline controller and buffers each returned word until its pipeline stage advances. A flush during an outstanding transaction lets the transaction finish on the bus and discards the result.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles without `bus_ack_i` before a transaction is aborted. Used only with `BUS_TIMEOUT_EN`; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-low
- stall  in  6  pipeline stall vector from the controller; bit 1 holds IF, bit 4 holds MEM
- flush  in  1  exception flush of the pipeline
- if_ce  in  1  fetch request
- if_addr  in  32  fetch address
- if_inst  out  32  fetched instruction (registered)
- stallreq_if  out  1  fetch not yet satisfied
- mem_ce  in  1  data request
- mem_we  in  1  1 = write
- mem_sel  in  4  byte lane selects
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data (registered)
- stallreq_mem  out  1  data access not yet satisfied
- bus_cyc_o, bus_stb_o  out  1 each  bus cycle and strobe
- bus_we_o  out  1  bus write enable
- bus_sel_o  out  4  bus byte selects
- bus_addr_o  out  32  bus address
- bus_data_o  out  32  bus write data
- bus_data_i  in  32  bus read data
- bus_ack_i  in  1  bus acknowledge
- bus_err_if, bus_err_mem  out  1 each  timeout flags

## Operation
- States: IDLE, BUSY_MEM, BUSY_IF, WAIT_FLUSH.
- Per-port flags `if_done` / `mem_done` mark a buffered result.
- Stall requests (combinational):
  - `stallreq_if = if_ce & ~if_done`
  - `stallreq_mem = mem_ce & ~mem_done`
- IDLE, with `flush`=0:
  - If `mem_ce & ~mem_done`: go to BUSY_MEM, register the bus outputs from the MEM port, and set cyc=stb=1.
  - Otherwise, if `if_ce & ~if_done`: go to BUSY_IF, drive addr=`if_addr`, we=0, sel=4'b1111.
  - Otherwise: remain in IDLE.
- IDLE with `flush`=1: no transaction starts that cycle.
- BUSY_x on `bus_ack_i`=1:
  - Deassert cyc, stb and we, and go to IDLE.
  - Set `x_done`.
  - On a read, capture `bus_data_i` into `if_inst` or `mem_rdata`. On a write, `mem_rdata` is unchanged.
- BUSY_x with `flush`=1 and no ack: go to WAIT_FLUSH. The bus outputs are held until ack.
- BUSY_x with `flush`=1 and ack in the same cycle: the result is discarded, no done flag is set, and the state goes to IDLE.
- WAIT_FLUSH on ack: deassert cyc and stb, go to IDLE, and discard the data.
- Done flags:
  - `if_done` clears at an edge with `stall[1]`=0.
  - `mem_done` clears at an edge with `stall[4]`=0.
  - Both clear at any edge with `flush`=1. Flush has priority over setting a flag.
- The bus outputs never change while cyc=1 and ack has not yet been seen.
- Reset (`rst`=0 at an edge) applies at any time, including mid-transaction:
  - State returns to IDLE and every output register goes to 0: `if_inst`, `mem_rdata`, and all `bus_*_o`.
  - Both done flags clear and the timeout counter clears.
  - Reset aborts the bus cycle.

## Timing
- Request first visible in IDLE at cycle N: cyc/stb high from N+1.
- Ack at cycle N+1+k: result register valid and stallreq low from N+2+k.
- Zero-wait slave (k=0): 2 stall cycles.
- MEM and IF both requesting in IDLE at cycle N:
  - MEM is served first.
  - The IF cycle starts at the earliest 2 cycles after the MEM ack: one IDLE cycle, then BUSY_IF.
- Back-to-back transactions always have at least one cycle with cyc=0 between them.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - An 8-bit counter increments in each BUSY_x or WAIT_FLUSH cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, cyc and stb drop and the state goes to IDLE.
  - In BUSY_x: `x_done` sets, the result register loads 0x00000000, and `bus_err_x` goes high. `bus_err_x` follows `x_done` and clears with it.
  - In WAIT_FLUSH: return to IDLE with no flag set.
  - The counter clears on each transaction start.
- `BUS_TIMEOUT_EN` undefined:
  - No counter is built, and transactions wait indefinitely for ack.
  - `bus_err_if` and `bus_err_mem` are tied to 0.

## Test plan
- Reset held for 3 cycles, then IF fetch of 0x00000100 with a slave acking in the first stb cycle, returning 0x3C010001 → all outputs 0 during reset; cyc high 1 cycle; `if_inst`=0x3C010001; `stallreq_if` high for exactly 2 cycles.
- IF and MEM requesting at the same time, MEM load of 0x00001000 with ack after 2 wait cycles → MEM is served first; `stallreq_if` stays high; IF bus cycle starts 2 cycles after the MEM ack.
- MEM store with sel=4'b0011 and data 0xDEADBEEF while `stall[4]` is held for 4 cycles after the ack → bus_we_o=1 and bus_sel_o=0011; `stallreq_mem` low after ack; no second bus cycle while `mem_done` is held.
- `flush` pulsed during the 2nd wait cycle of an IF read → bus held until ack; `if_inst` unchanged; `if_done` stays 0; next fetch issues normally.
- `rst` asserted in the middle of a BUSY_MEM wait → next cycle cyc=stb=0, state IDLE, `mem_rdata`=0.
- `BUS_TIMEOUT_EN` defined, TIMEOUT_CYCLES=4, slave never acks → cyc drops after 4 BUSY cycles; `bus_err_mem`=1; `mem_rdata`=0; `stallreq_mem` low.
